// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types, constants and enable-priority helper for pipeline_ctrl
package pipeline_ctrl_pkg;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

    localparam int DIV_CYCLES_DEF = 32;
    localparam int DIV_CNT_W      = 6;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idexe_en;
        logic idexe_bubble;
        logic exemem_en;
    } stage_en_t;

    // Reset beats bus wait, bus wait beats hazards; a hazard freezes the front end and bubbles EXE.
    function automatic stage_en_t stage_en_sel(input logic run, input logic bus_stall,
                                               input logic hazard);
        stage_en_t en;
        if (!run) begin
            en = '{pc_en: 1'b0, ifid_en: 1'b0, idexe_en: 1'b0, idexe_bubble: 1'b1, exemem_en: 1'b0};
        end else if (bus_stall) begin
            en = '{pc_en: 1'b0, ifid_en: 1'b0, idexe_en: 1'b0, idexe_bubble: 1'b0, exemem_en: 1'b0};
        end else if (hazard) begin
            en = '{pc_en: 1'b0, ifid_en: 1'b0, idexe_en: 1'b1, idexe_bubble: 1'b1, exemem_en: 1'b1};
        end else begin
            en = '{pc_en: 1'b1, ifid_en: 1'b1, idexe_en: 1'b1, idexe_bubble: 1'b0, exemem_en: 1'b1};
        end
        return en;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - ID/EXE hazard inputs and stage-enable outputs of pipeline_ctrl
interface pipeline_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_is_div;
    logic        id_uses_hilo;
    logic [4:0]  exe_reg;
    logic        exe_write_regfile;
    logic        exe_mem_to_regfile;
    logic        bus_stall;
    logic        pc_en;
    logic        ifid_en;
    logic        idexe_en;
    logic        idexe_bubble;
    logic        exemem_en;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_is_div, id_uses_hilo,
               exe_reg, exe_write_regfile, exe_mem_to_regfile, bus_stall,
        input  pc_en, ifid_en, idexe_en, idexe_bubble, exemem_en,
               div_start, div_busy, div_done, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_div, id_uses_hilo,
               exe_reg, exe_write_regfile, exe_mem_to_regfile, bus_stall,
        output pc_en, ifid_en, idexe_en, idexe_bubble, exemem_en,
               div_start, div_busy, div_done, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - combinational load-use and HI/LO hazard detection
module pipeline_ctrl_hazard_detect (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_div,
    input  logic       id_uses_hilo,
    input  logic [4:0] exe_reg,
    input  logic       exe_write_regfile,
    input  logic       exe_mem_to_regfile,
    input  logic       div_busy,
    output logic       lu,
    output logic       hh
);
    logic src_match;

    always_comb begin
        src_match = (id_use_rs && (id_rs == exe_reg)) || (id_use_rt && (id_rt == exe_reg));
        // $0 is never a real producer, so a load targeting it cannot create a dependency.
        lu = exe_mem_to_regfile && exe_write_regfile && (exe_reg != 5'd0) && src_match;
        hh = div_busy && (id_uses_hilo || id_is_div);
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/bubble sequencer, divider tracker and stall counter beside ID
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave pif
);
    localparam logic [DIV_CNT_W-1:0] DIV_RELOAD = DIV_CNT_W'(DIV_CYCLES - 1);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic                 div_start_q, div_start_d;
    logic                 div_done_q, div_done_d;
    logic [31:0]          stall_cycles_q, stall_cycles_d;

    logic      lu;
    logic      hh;
    logic      div_busy;
    logic      div_issue;
    stage_en_t en;

    assign div_busy = (state_q == DIV_BUSY);

    pipeline_ctrl_hazard_detect u_hazard (
        .id_rs             (pif.id_rs),
        .id_rt             (pif.id_rt),
        .id_use_rs         (pif.id_use_rs),
        .id_use_rt         (pif.id_use_rt),
        .id_is_div         (pif.id_is_div),
        .id_uses_hilo      (pif.id_uses_hilo),
        .exe_reg           (pif.exe_reg),
        .exe_write_regfile (pif.exe_write_regfile),
        .exe_mem_to_regfile(pif.exe_mem_to_regfile),
        .div_busy          (div_busy),
        .lu                (lu),
        .hh                (hh)
    );

    always_comb begin
        en        = stage_en_sel(reset, pif.bus_stall, lu || hh);
        // A DIV issues only when it actually advances into EXE as a real instruction.
        div_issue = pif.id_is_div && en.idexe_en && !en.idexe_bubble && !div_busy;

        state_d        = state_q;
        div_cnt_d      = div_cnt_q;
        div_start_d    = 1'b0;
        div_done_d     = 1'b0;
        stall_cycles_d = stall_cycles_q + {31'd0, !en.pc_en};

        case (state_q)
            DIV_IDLE: begin
                if (div_issue) begin
                    state_d     = DIV_BUSY;
                    div_cnt_d   = DIV_RELOAD;
                    div_start_d = 1'b1;
                end
            end
            DIV_BUSY: begin
                // Counts through bus waits too: the divider runs on its own once started.
                if (div_cnt_q == '0) begin
                    state_d    = DIV_IDLE;
                    div_done_d = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= DIV_IDLE;
            div_cnt_q      <= '0;
            div_start_q    <= 1'b0;
            div_done_q     <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            div_cnt_q      <= div_cnt_d;
            div_start_q    <= div_start_d;
            div_done_q     <= div_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pif.pc_en        = en.pc_en;
    assign pif.ifid_en      = en.ifid_en;
    assign pif.idexe_en     = en.idexe_en;
    assign pif.idexe_bubble = en.idexe_bubble;
    assign pif.exemem_en    = en.exemem_en;
    assign pif.div_start    = div_start_q;
    assign pif.div_busy     = div_busy;
    assign pif.div_done     = div_done_q;
    assign pif.stall_cycles = stall_cycles_q;
endmodule
